// File: rtl/fp_div_sqrt_arbiter_pkg.sv
// rtl/fp_div_sqrt_arbiter_pkg.sv - shared types and latency constants for the div/sqrt arbiter
package fp_div_sqrt_arbiter_pkg;

  localparam int FDIV_LATENCY  = 16;
  localparam int FSQRT_LATENCY = 15;

  // Payload fields are sized for the widest supported configuration; the top uses the low bits.
  localparam int DSA_MAX_TAG = 16;
  localparam int DSA_MAX_ID  = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } DivSqrtArbState;

  typedef struct packed {
    logic [31:0]            lhs;
    logic [31:0]            rhs;
    logic                   is_divide;
    logic [DSA_MAX_TAG-1:0] tag;
    logic [DSA_MAX_ID-1:0]  id;
  } DivSqrtReqPayload;

endpackage

// File: rtl/fp_div_sqrt_arbiter_rr_arbiter.sv
// rtl/fp_div_sqrt_arbiter_rr_arbiter.sv - round-robin pick of the first eligible index at or after the pointer
module rr_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  i_eligible,
  input  logic [ID_WIDTH-1:0] i_ptr,
  output logic [NUM_REQ-1:0]  o_grant,
  output logic [ID_WIDTH-1:0] o_idx
);

  int   w_k;
  logic w_found;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_k     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_k = (int'(i_ptr) + i) % NUM_REQ;
      if (!w_found && i_eligible[w_k]) begin
        w_found      = 1'b1;
        o_grant[w_k] = 1'b1;
        o_idx        = ID_WIDTH'(w_k);
      end
    end
  end

endmodule

// File: rtl/fp_div_sqrt_arbiter.sv
// rtl/fp_div_sqrt_arbiter.sv - shares one multicycle FP32 div/sqrt unit among NUM_REQ requesters
module fp_div_sqrt_arbiter
  import fp_div_sqrt_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int TAG_WIDTH = 6,
  parameter int ID_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ-1:0][31:0]           req_lhs,
  input  logic [NUM_REQ-1:0][31:0]           req_rhs,
  input  logic [NUM_REQ-1:0]                 req_is_divide,
  input  logic [NUM_REQ-1:0][TAG_WIDTH-1:0]  req_tag,
  input  logic [NUM_REQ-1:0]                 flush,
  output logic                               resp_valid,
  input  logic                               resp_ready,
  output logic [ID_WIDTH-1:0]                resp_id,
  output logic [TAG_WIDTH-1:0]               resp_tag,
  output logic [31:0]                        resp_result,
  output logic                               busy,
  output logic                               unit_req,
  output logic [31:0]                        unit_lhs,
  output logic [31:0]                        unit_rhs,
  output logic                               unit_is_divide,
  input  logic                               unit_finished,
  input  logic [31:0]                        unit_result
);

  DivSqrtArbState   r_state, w_state_nxt;
  DivSqrtReqPayload r_pay, w_pay_nxt;
  logic [ID_WIDTH-1:0] r_ptr, w_ptr_nxt, w_win_idx, w_own;
  logic [NUM_REQ-1:0]  w_eligible, w_grant;
  logic [31:0]         r_result, w_result_nxt;
  logic r_killed, w_killed_nxt, r_wait_first, w_wait_first_nxt;
  logic w_own_flush;
  logic w_unused_pay;

  assign w_eligible   = req_valid & ~flush;
  assign w_own        = r_pay.id[ID_WIDTH-1:0];
  assign w_own_flush  = flush[w_own];
  assign w_unused_pay = ^{r_pay.tag, r_pay.id};

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) u_rr (
    .i_eligible (w_eligible),
    .i_ptr      (r_ptr),
    .o_grant    (w_grant),
    .o_idx      (w_win_idx)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_pay_nxt        = r_pay;
    w_ptr_nxt        = r_ptr;
    w_result_nxt     = r_result;
    w_killed_nxt     = r_killed;
    w_wait_first_nxt = r_wait_first;
    req_ready        = '0;
    resp_valid       = 1'b0;
    unit_req         = 1'b0;
    case (r_state)
      IDLE: begin
        // A low unit_finished means the unit is still busy (e.g. after a reset mid-op).
        if ((|w_eligible) && unit_finished) begin
          req_ready                       = w_grant;
          w_pay_nxt                       = '0;
          w_pay_nxt.lhs                   = req_lhs[w_win_idx];
          w_pay_nxt.rhs                   = req_rhs[w_win_idx];
          w_pay_nxt.is_divide             = req_is_divide[w_win_idx];
          w_pay_nxt.tag[TAG_WIDTH-1:0]    = req_tag[w_win_idx];
          w_pay_nxt.id[ID_WIDTH-1:0]      = w_win_idx;
          w_ptr_nxt    = (w_win_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_win_idx + ID_WIDTH'(1);
          w_killed_nxt = 1'b0;
          w_state_nxt  = ISSUE;
        end
      end
      ISSUE: begin
        unit_req         = 1'b1;
        w_wait_first_nxt = 1'b1;
        if (w_own_flush) w_killed_nxt = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        w_wait_first_nxt = 1'b0;
        if (w_own_flush) w_killed_nxt = 1'b1;
        if (!r_wait_first && unit_finished) begin
          w_result_nxt = unit_result;
          w_state_nxt  = (r_killed || w_own_flush) ? IDLE : DONE;
        end
      end
      DONE: begin
        resp_valid = ~r_killed & ~w_own_flush;
        if (w_own_flush) begin
          w_killed_nxt = 1'b1;
          w_state_nxt  = IDLE;
        end else if (resp_valid && resp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_pay        <= '0;
      r_ptr        <= '0;
      r_result     <= '0;
      r_killed     <= 1'b0;
      r_wait_first <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pay        <= w_pay_nxt;
      r_ptr        <= w_ptr_nxt;
      r_result     <= w_result_nxt;
      r_killed     <= w_killed_nxt;
      r_wait_first <= w_wait_first_nxt;
    end
  end

  assign busy           = (r_state != IDLE);
  assign unit_lhs       = r_pay.lhs;
  assign unit_rhs       = r_pay.rhs;
  assign unit_is_divide = r_pay.is_divide;
  assign resp_id        = w_own;
  assign resp_tag       = r_pay.tag[TAG_WIDTH-1:0];
  assign resp_result    = r_result;

endmodule

// File: tb/tb_fp_div_sqrt_arbiter.sv
// tb/tb_fp_div_sqrt_arbiter.sv - self-checking bench with a behavioural div/sqrt unit and arbiter model
module tb_fp_div_sqrt_arbiter;
  import fp_div_sqrt_arbiter_pkg::*;

  localparam int N  = 2;
  localparam int TW = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0]          req_valid = '0;
  logic [N-1:0]          req_ready;
  logic [N-1:0][31:0]    req_lhs = '0;
  logic [N-1:0][31:0]    req_rhs = '0;
  logic [N-1:0]          req_is_divide = '0;
  logic [N-1:0][TW-1:0]  req_tag = '0;
  logic [N-1:0]          flush = '0;
  logic                  resp_valid;
  logic                  resp_ready = 1'b0;
  logic [0:0]            resp_id;
  logic [TW-1:0]         resp_tag;
  logic [31:0]           resp_result;
  logic                  busy, unit_req, unit_is_divide;
  logic [31:0]           unit_lhs, unit_rhs;
  logic                  unit_finished = 1'b1;
  logic [31:0]           unit_result = '0;
  logic [31:0]           u_pend = '0;
  int cnt = 0;
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  fp_div_sqrt_arbiter #(.NUM_REQ(N), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_lhs(req_lhs), .req_rhs(req_rhs), .req_is_divide(req_is_divide), .req_tag(req_tag),
    .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_tag(resp_tag), .resp_result(resp_result),
    .busy(busy),
    .unit_req(unit_req), .unit_lhs(unit_lhs), .unit_rhs(unit_rhs),
    .unit_is_divide(unit_is_divide), .unit_finished(unit_finished), .unit_result(unit_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] unit_fn(input logic [31:0] a, input logic [31:0] b, input logic dv);
    if (dv && a == 32'h40400000 && b == 32'h40000000) return 32'h3FC00000;
    if (!dv && a == 32'h40800000) return 32'h40000000;
    if (a[30:23] == 8'hFF && a[22:0] != 23'd0) return 32'h7FC00000;
    if (!dv && a[31] && a[30:0] != 31'd0) return 32'h7FC00000;
    if (dv && b[30:0] == 31'd0 && a[30:0] != 31'd0) return {a[31] ^ b[31], 31'h7F800000};
    return a ^ {b[15:0], b[31:16]} ^ {31'd0, dv};
  endfunction

  // Behavioural div/sqrt unit; deliberately not tied to the DUT reset.
  always @(posedge clk) begin
    if (unit_req) begin
      unit_finished <= 1'b0;
      cnt    <= (unit_is_divide ? FDIV_LATENCY : FSQRT_LATENCY) - 1;
      u_pend <= unit_fn(unit_lhs, unit_rhs, unit_is_divide);
    end else if (cnt > 0) begin
      if (cnt == 1) begin
        unit_finished <= 1'b1;
        unit_result   <= u_pend;
      end
      cnt <= cnt - 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input int i, output int t);
    t = -1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        t = cyc;
        return;
      end
    end
    chk("grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_resp(output int t);
    t = -1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        t = cyc;
        return;
      end
    end
    chk("resp_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (!busy) return;
    end
    chk("idle_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    int          id;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic        dv;
    logic [5:0]  tag;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    int          id;
    logic [5:0]  tag;
    logic [31:0] res;
    int          t;
    int          lat;
  } exp_t;

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    vec_t vecs[5];
    exp_t q[$];
    int t, t2, d, r, prev_t, m_ptr, first_seen, w;
    int order[6];
    bit saw, m_free;
    logic [31:0] r0;
    logic [N-1:0] eg, acc;

    vecs[0] = '{0, 32'h40400000, 32'h40000000, 1'b1, 6'd5,  32'h3FC00000, 18};
    vecs[1] = '{1, 32'h40800000, 32'h00000000, 1'b0, 6'd9,  32'h40000000, 17};
    vecs[2] = '{0, 32'hC0800000, 32'h00000000, 1'b0, 6'h2A, 32'h7FC00000, 17};
    vecs[3] = '{0, 32'h3F800000, 32'h00000000, 1'b1, 6'h3F, 32'h7F800000, 18};
    vecs[4] = '{1, 32'h7FC00000, 32'h3F800000, 1'b1, 6'd0,  32'h7FC00000, 18};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_unit_req", 32'(unit_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;

    // Directed single operations
    resp_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      tick();
      req_valid[vecs[v].id]     = 1'b1;
      req_lhs[vecs[v].id]       = vecs[v].lhs;
      req_rhs[vecs[v].id]       = vecs[v].rhs;
      req_is_divide[vecs[v].id] = vecs[v].dv;
      req_tag[vecs[v].id]       = vecs[v].tag;
      wait_grant(vecs[v].id, t);
      tick();
      req_valid = '0;
      @(negedge clk);
      chk("vec_unit_req", 32'(unit_req), 32'd1);
      wait_resp(r);
      chk("vec_latency", 32'(r - t), 32'(vecs[v].lat));
      chk("vec_result", resp_result, vecs[v].exp);
      chk("vec_id", 32'(resp_id), 32'(vecs[v].id));
      chk("vec_tag", 32'(resp_tag), 32'(vecs[v].tag));
      tick();
    end

    // Fairness: both requesters continuously valid
    tick();
    req_lhs = {32'h40000000, 32'h3F800000};
    req_rhs = {32'h3F800000, 32'h40000000};
    req_is_divide = 2'b11;
    req_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      order[k] = -1;
      for (int j = 0; j < 80; j++) begin
        @(negedge clk);
        if (req_ready != '0) begin
          order[k] = req_ready[1] ? 1 : 0;
          break;
        end
      end
      chk("fair_order", 32'(order[k]), 32'(k % 2));
    end
    tick();
    req_valid = '0;
    wait_idle();

    // Only requester 1: back-to-back grants one cycle after each handshake
    tick();
    req_valid = 2'b10;
    prev_t = -1;
    for (int k = 0; k < 3; k++) begin
      wait_grant(1, t);
      if (prev_t >= 0) chk("b2b_gap", 32'(t - prev_t), 32'(FDIV_LATENCY + 3));
      prev_t = t;
    end
    tick();
    req_valid = '0;
    wait_idle();

    // Flush of owner in WAIT
    tick();
    req_is_divide = 2'b01;
    req_lhs[1] = 32'h40800000;
    req_valid = 2'b01;
    wait_grant(0, t);
    tick();
    req_valid = 2'b10;
    saw = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      if (k == 5) flush[0] = 1'b1;
      if (k == 6) flush[0] = 1'b0;
      @(negedge clk);
      saw |= resp_valid;
      tick();
    end
    chk("flush_wait_no_resp", 32'(saw), 32'd0);
    @(negedge clk);
    chk("flush_wait_busy", 32'(busy), 32'd0);
    chk("flush_wait_next_grant", 32'(req_ready), 32'b10);
    t2 = cyc;
    tick();
    req_valid = '0;
    resp_ready = 1'b0;

    // Flush of owner in DONE while backpressured
    wait_resp(d);
    chk("flush_done_lat", 32'(d - t2), 32'(FSQRT_LATENCY + 2));
    tick();
    flush[1] = 1'b1;
    @(negedge clk);
    chk("flush_done_valid", 32'(resp_valid), 32'd0);
    chk("flush_done_busy", 32'(busy), 32'd1);
    tick();
    flush[1] = 1'b0;
    @(negedge clk);
    chk("flush_done_idle", 32'(busy), 32'd0);

    // Backpressure for 10 cycles in DONE
    tick();
    req_lhs[0] = 32'h40400000;
    req_rhs[0] = 32'h3F000000;
    req_tag[0] = 6'd7;
    req_valid = 2'b01;
    wait_grant(0, t);
    tick();
    req_valid = 2'b10;
    wait_resp(d);
    r0 = resp_result;
    chk("bp_result", r0, unit_fn(32'h40400000, 32'h3F000000, 1'b1));
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      chk("bp_stable", 32'({resp_valid, resp_result == r0, resp_id == 1'b0, resp_tag == 6'd7, req_ready == 2'b00}),
          32'b11111);
      tick();
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_handshake_valid", 32'(resp_valid), 32'd1);
    tick();
    @(negedge clk);
    chk("bp_idle", 32'(busy), 32'd0);
    chk("bp_next_grant", 32'(req_ready), 32'b10);
    tick();
    req_valid = '0;
    wait_idle();

    // Reset during WAIT while the unit keeps finished low for 5 more cycles
    tick();
    req_valid = 2'b01;
    wait_grant(0, t);
    while (cyc < t + 12) tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_unit_req", 32'(unit_req), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    saw = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      saw |= (req_ready != '0);
      tick();
    end
    chk("rst_no_grant_while_unit_busy", 32'(saw), 32'd0);
    @(negedge clk);
    chk("rst_grant_after_finished", 32'(req_ready), 32'b01);
    tick();
    req_valid = '0;
    wait_idle();

    // Valid and flush on the same requester: no grant
    tick();
    req_valid = 2'b01;
    flush = 2'b01;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("flush_same_no_grant", 32'(req_ready), 32'd0);
      tick();
    end
    req_valid = 2'b11;
    @(negedge clk);
    chk("flush_same_other_grant", 32'(req_ready), 32'b10);
    tick();
    req_valid = '0;
    flush = '0;
    wait_idle();

    // Randomized traffic against a transaction-level model; last grant went to 1, so pointer is 0
    m_ptr = 0;
    m_free = 1'b1;
    first_seen = 0;
    tick();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      eg = '0;
      if (m_free && unit_finished && req_valid != '0) begin
        for (int j = 0; j < N; j++) begin
          w = (m_ptr + j) % N;
          if (req_valid[w]) begin
            eg[w] = 1'b1;
            break;
          end
        end
      end
      chk("rand_grant", 32'(req_ready), 32'(eg));
      acc = req_ready;
      if (eg != '0) begin
        w = eg[1] ? 1 : 0;
        q.push_back('{w, req_tag[w], unit_fn(req_lhs[w], req_rhs[w], req_is_divide[w]), cyc,
                      req_is_divide[w] ? FDIV_LATENCY : FSQRT_LATENCY});
        m_ptr = (w + 1) % N;
        m_free = 1'b0;
      end
      if (resp_valid) begin
        if (q.size() == 0) begin
          chk("rand_spurious_resp", 32'd1, 32'd0);
        end else begin
          if (first_seen == 0) begin
            chk("rand_latency", 32'(cyc - q[0].t), 32'(q[0].lat + 2));
            first_seen = 1;
          end
          if (resp_ready) begin
            chk("rand_result", resp_result, q[0].res);
            chk("rand_id", 32'(resp_id), 32'(q[0].id));
            chk("rand_tag", 32'(resp_tag), 32'(q[0].tag));
            void'(q.pop_front());
            m_free = 1'b1;
            first_seen = 0;
          end
        end
      end
      tick();
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          req_valid[i] = 1'b0;
        end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          req_valid[i]     = 1'b1;
          req_lhs[i]       = $urandom;
          req_rhs[i]       = $urandom;
          req_is_divide[i] = 1'($urandom_range(0, 1));
          req_tag[i]       = 6'($urandom_range(0, 63));
        end
      end
      resp_ready = ($urandom_range(0, 2) != 0);
    end
    req_valid = '0;
    resp_ready = 1'b1;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
